// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_responder data-memory slave.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned DEPTH_DEF = 512;
  localparam int unsigned WORD_AW   = 9;
  // Any set bit above the 2 KiB window makes the access out of range.
  localparam logic [31:0] OOR_MASK  = 32'hFFFF_F800;

  function automatic logic addr_oor(input logic [31:0] addr);
    return (addr & OOR_MASK) != '0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with a byte-enabled write port, a registered read port and,
// when DMEM_EXT_PORT_EN is defined, a second free-running registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [WORD_AW-1:0] waddr_i,
  input  logic [31:0]        wdata_i,
  input  logic               re_i,
  input  logic [WORD_AW-1:0] raddr_i,
  output logic [31:0]        rdata_o,
  input  logic [WORD_AW-1:0] ext_addr_i,
  output logic [31:0]        ext_data_o
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  // NOTE: the storage array has no reset branch on purpose: contents survive
  // reset and the array maps onto RAM macros; only the read registers reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

`ifdef DMEM_EXT_PORT_EN
  logic [31:0] ext_q;

  // Read-before-write: a same-cycle store to ext_addr shows up one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ext_q <= '0;
    else     ext_q <= mem[ext_addr_i];
  end

  assign ext_data_o = ext_q;
`else
  logic unused_ext;
  assign unused_ext = ^ext_addr_i;
  assign ext_data_o = '0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a fixed LATENCY between
// request acceptance and response; storage lives in dmem_array.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [3:0]         req_be,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [31:0]        resp_rdata,
  output logic               resp_err,
  input  logic [WORD_AW-1:0] ext_addr,
  output logic [31:0]        ext_data
);

  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q;
  logic               we_q, err_q;
  logic [WORD_AW-1:0] idx_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;

  logic               accept, enter_resp;
  logic               cur_we, cur_err;
  logic [WORD_AW-1:0] cur_idx;
  logic [31:0]        cur_wdata, arr_rdata;
  logic [3:0]         cur_be;

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational block assigns its outputs a default first so
  // that no path through the case statement leaves a latch behind.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE) && !reset;
    resp_valid = (state_q == RESP);
    resp_err   = (state_q == RESP) && err_q;
    resp_rdata = ((state_q == RESP) && !we_q && !err_q) ? arr_rdata : '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      cnt_q   <= CNT_INIT;
      we_q    <= req_we;
      err_q   <= addr_oor(req_addr);
      idx_q   <= req_addr[WORD_AW+1:2];
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end else if (state_q == WAIT && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // With LATENCY=0 the memory access happens on the acceptance edge itself,
  // before the request registers are loaded, so use the live inputs then.
  always_comb begin
    cur_we    = (state_q == IDLE) ? req_we                 : we_q;
    cur_err   = (state_q == IDLE) ? addr_oor(req_addr)     : err_q;
    cur_idx   = (state_q == IDLE) ? req_addr[WORD_AW+1:2]  : idx_q;
    cur_wdata = (state_q == IDLE) ? req_wdata              : wdata_q;
    cur_be    = (state_q == IDLE) ? req_be                 : be_q;
  end

  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk        (clk),
    .rst        (reset),
    .we_i       (enter_resp && cur_we && !cur_err),
    .be_i       (cur_be),
    .waddr_i    (cur_idx),
    .wdata_i    (cur_wdata),
    .re_i       (enter_resp && !cur_we && !cur_err),
    .raddr_i    (cur_idx),
    .rdata_o    (arr_rdata),
    .ext_addr_i (ext_addr),
    .ext_data_o (ext_data)
  );

endmodule
